// File: rtl/usb_fs_diff_tx.sv
// Full-speed USB serial transmitter: SYNC, LSB-first NRZI data with bit stuffing, and EOP on dp/dn/oe.
// Define USB_FS_DIFF_TX_OBS_EN to expose the registered pre-NRZI data bit on usb_diff_tx_obs_o.
module usb_fs_diff_tx #(
  parameter int unsigned StuffLen   = 6,
  parameter int unsigned EopSe0Bits = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       bit_en_i,
  input  logic [7:0] data_i,
  input  logic       data_valid_i,
  input  logic       data_last_i,
  output logic       data_ready_o,
  output logic       usb_dp_o,
  output logic       usb_dn_o,
  output logic       usb_oe_o,
  output logic       busy_o,
  output logic       underrun_o,
  output logic       usb_diff_tx_obs_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_STUFF,
    ST_EOP_SE0,
    ST_EOP_J
  } state_t;

  localparam logic [2:0] STUFF_LEN = 3'(StuffLen);
  localparam logic [1:0] EOP_LAST  = 2'(EopSe0Bits - 1);

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  ones_q, ones_d;
  logic [1:0]  eop_cnt_q, eop_cnt_d;
  logic        ret_eop_q, ret_eop_d;
  logic        last_q, last_d;
  logic        level_q, level_d;
  logic        dp_q, dp_d;
  logic        dn_q, dn_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
  logic        underrun_q, underrun_d;
  logic [7:0]  shift_q, shift_d;

  logic        emit;
  logic        line_bit;
  logic [2:0]  ones_next;
  logic        goto_eop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      ones_q     <= 3'd0;
      eop_cnt_q  <= 2'd0;
      ret_eop_q  <= 1'b0;
      last_q     <= 1'b0;
      level_q    <= 1'b1;
      dp_q       <= 1'b1;
      dn_q       <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      ones_q     <= ones_d;
      eop_cnt_q  <= eop_cnt_d;
      ret_eop_q  <= ret_eop_d;
      last_q     <= last_d;
      level_q    <= level_d;
      dp_q       <= dp_d;
      dn_q       <= dn_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
    end
  end

  // Byte shift register is pure data and carries no reset.
  always_ff @(posedge clk_i) begin
    shift_q <= shift_d;
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    ones_d       = ones_q;
    eop_cnt_d    = eop_cnt_q;
    ret_eop_d    = ret_eop_q;
    last_d       = last_q;
    shift_d      = shift_q;
    level_d      = level_q;
    dp_d         = dp_q;
    dn_d         = dn_q;
    oe_d         = oe_q;
    busy_d       = busy_q;
    underrun_d   = 1'b0;
    data_ready_o = 1'b0;
    emit         = 1'b0;
    line_bit     = 1'b0;
    ones_next    = 3'd0;
    goto_eop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          shift_d   = data_i;
          last_d    = data_last_i;
          busy_d    = 1'b1;
          bit_cnt_d = 3'd0;
          ones_d    = 3'd0;
          state_d   = ST_SYNC;
        end
      end
      ST_SYNC: if (bit_en_i) begin
        emit      = 1'b1;
        line_bit  = (bit_cnt_q == 3'd7);
        ones_d    = line_bit ? ones_q + 3'd1 : 3'd0;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = ST_DATA;
      end
      ST_DATA: if (bit_en_i) begin
        emit      = 1'b1;
        line_bit  = shift_q[bit_cnt_q];
        ones_next = line_bit ? ones_q + 3'd1 : 3'd0;
        ones_d    = ones_next;
        bit_cnt_d = bit_cnt_q + 3'd1;
        // Refill slot: the next byte is taken in the same tick that sends bit 7.
        if (bit_cnt_q == 3'd7) begin
          if (last_q) begin
            goto_eop = 1'b1;
          end else begin
            data_ready_o = 1'b1;
            if (data_valid_i) begin
              shift_d = data_i;
              last_d  = data_last_i;
            end else begin
              underrun_d = 1'b1;
              goto_eop   = 1'b1;
            end
          end
        end
        if (ones_next == STUFF_LEN) begin
          state_d   = ST_STUFF;
          ret_eop_d = goto_eop;
        end else if (goto_eop) begin
          state_d   = ST_EOP_SE0;
          eop_cnt_d = 2'd0;
        end
      end
      ST_STUFF: if (bit_en_i) begin
        emit      = 1'b1;
        line_bit  = 1'b0;
        ones_d    = 3'd0;
        eop_cnt_d = 2'd0;
        state_d   = ret_eop_q ? ST_EOP_SE0 : ST_DATA;
      end
      ST_EOP_SE0: if (bit_en_i) begin
        dp_d      = 1'b0;
        dn_d      = 1'b0;
        oe_d      = 1'b1;
        eop_cnt_d = eop_cnt_q + 2'd1;
        if (eop_cnt_q == EOP_LAST) begin
          state_d   = ST_EOP_J;
          eop_cnt_d = 2'd0;
        end
      end
      ST_EOP_J: if (bit_en_i) begin
        // First tick drives J; the following tick releases the pad.
        if (eop_cnt_q == 2'd0) begin
          dp_d      = 1'b1;
          dn_d      = 1'b0;
          eop_cnt_d = 2'd1;
        end else begin
          dp_d      = 1'b1;
          dn_d      = 1'b0;
          oe_d      = 1'b0;
          busy_d    = 1'b0;
          level_d   = 1'b1;
          ones_d    = 3'd0;
          bit_cnt_d = 3'd0;
          eop_cnt_d = 2'd0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (emit) begin
      level_d = line_bit ? level_q : ~level_q;
      dp_d    = level_d;
      dn_d    = ~level_d;
      oe_d    = 1'b1;
    end
  end

  assign usb_dp_o   = dp_q;
  assign usb_dn_o   = dn_q;
  assign usb_oe_o   = oe_q;
  assign busy_o     = busy_q;
  assign underrun_o = underrun_q;

`ifdef USB_FS_DIFF_TX_OBS_EN
  logic obs_q;

  // Stuff bits and EOP/idle ticks carry line_bit = 0, so they show as 0 here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      obs_q <= 1'b0;
    end else if (bit_en_i) begin
      obs_q <= emit & line_bit;
    end
  end

  assign usb_diff_tx_obs_o = obs_q;
`else
  assign usb_diff_tx_obs_o = 1'b0;
`endif

endmodule
